// File: rtl/bpi_pkg.sv
// bpi_pkg: BPI op codes, flash command words and auto-save sequencer state types.
package bpi_pkg;
    localparam logic [1:0]  OP_CMD         = 2'b00;
    localparam logic [1:0]  OP_PROG        = 2'b01;
    localparam logic [1:0]  OP_READ        = 2'b10;
    localparam logic [1:0]  OP_CONF        = 2'b11;
    localparam logic [15:0] CMD_UNLOCK     = 16'h0060;
    localparam logic [15:0] CMD_ERASE      = 16'h0020;
    localparam logic [15:0] CMD_READ_ARRAY = 16'h00FF;

    typedef enum logic [2:0] {
        S_IDLE, S_UNLOCK, S_ERASE, S_LOAD, S_PROG, S_RDARR, S_DONE, S_ABORT
    } as_state_e;

    typedef enum logic [1:0] {PH_ISSUE, PH_WAIT, PH_ACK} as_phase_e;

    // States that launch a BPI op and walk through ISSUE/WAIT/ACK
    function automatic logic is_op(input as_state_e s);
        return s inside {S_UNLOCK, S_ERASE, S_PROG, S_RDARR, S_ABORT};
    endfunction
endpackage

// File: rtl/auto_save_FSM.sv
// auto_save_FSM: auto-save state/phase sequencer with ISSUE/WAIT/ACK handshake per flash op.
// Defining AUTO_SAVE_UNLOCK_EN inserts the UNLOCK op ahead of ERASE.
module auto_save_FSM
    import bpi_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  logic      start_i,
    input  logic      busy_i,
    input  logic      done_i,
    input  logic      tmo_hit_i,
    input  logic      last_i,
    output as_state_e state_o,
    output as_phase_e phase_o,
    output logic      fire_o,
    output logic      ack_o,
    output logic      latch_o
);
`ifdef AUTO_SAVE_UNLOCK_EN
    localparam as_state_e FIRST_OP = S_UNLOCK;
`else
    localparam as_state_e FIRST_OP = S_ERASE;
`endif

    as_state_e state_q, state_d, next_op;
    as_phase_e phase_q, phase_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            phase_q <= PH_ISSUE;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        next_op = state_q == S_UNLOCK ? S_ERASE :
                  state_q == S_ERASE  ? S_LOAD  :
                  state_q == S_PROG   ? (last_i ? S_RDARR : S_LOAD) :
                  state_q == S_RDARR  ? S_DONE  : S_IDLE;
        state_d = state_q;
        phase_d = phase_q;
        if (state_q == S_IDLE) begin
            phase_d = PH_ISSUE;
            state_d = start_i ? FIRST_OP : S_IDLE;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end else if (state_q == S_LOAD) begin
            // first cycle presents the read index, second cycle latches the word
            phase_d = phase_q == PH_ISSUE ? PH_WAIT : PH_ISSUE;
            state_d = phase_q == PH_ISSUE ? S_LOAD : S_PROG;
        end else if (phase_q == PH_ISSUE) begin
            phase_d = busy_i ? PH_ISSUE : PH_WAIT;
        end else if (phase_q == PH_WAIT) begin
            if (done_i) begin
                phase_d = PH_ACK;
            end else if (tmo_hit_i) begin
                state_d = S_ABORT;
                phase_d = PH_ISSUE;
            end
        end else begin
            state_d = next_op;
            phase_d = PH_ISSUE;
        end
    end

    always_comb begin
        fire_o  = is_op(state_q) && phase_q == PH_ISSUE && !busy_i;
        ack_o   = is_op(state_q) && phase_q == PH_ACK;
        latch_o = state_q == S_LOAD && phase_q == PH_WAIT;
    end

    assign state_o = state_q;
    assign phase_o = phase_q;
endmodule

// File: rtl/auto_save_const.sv
// auto_save_const: writes NWORDS constants into the last BPI parameter block (erase, program, read array).
// Defining AUTO_SAVE_UNLOCK_EN adds a block unlock before the erase.
module auto_save_const
    import bpi_pkg::*;
#(
    parameter logic [22:0] BASE_ADDR  = 23'h7FC000,
    parameter int          NWORDS     = 64,
    parameter logic [31:0] TMO_CYCLES = 32'd80000000
)(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        AS_START,
    input  logic        BUSY,
    input  logic        AS_DONE,
    input  logic [15:0] AS_DATA_IN,
    output logic [5:0]  AS_RD_ADDR,
    output logic [22:0] AS_ADDR,
    output logic [15:0] AS_CMD_DATA_OUT,
    output logic [1:0]  AS_OP,
    output logic        AS_EXECUTE,
    output logic        AUTO_SAVE_ENA,
    output logic        CLR_AS_DONE,
    output logic [5:0]  AS_CNT,
    output logic [2:0]  AS_STATUS
);
    localparam logic [5:0] LAST = 6'(NWORDS - 1);

    as_state_e   state;
    as_phase_e   phase;
    logic        fire, ack, latch, last, accept, waiting, tmo_hit, exec_q;
    logic [5:0]  offset_q, offset_d, cnt_q, cnt_d;
    logic [15:0] data_q, data_d;
    logic [31:0] tmo_q, tmo_d;
    logic [2:0]  status_q, status_d;

    auto_save_FSM u_fsm (
        .clk_i     (CLK),
        .rst_n_i   (RST_N),
        .start_i   (AS_START),
        .busy_i    (BUSY),
        .done_i    (AS_DONE),
        .tmo_hit_i (tmo_hit),
        .last_i    (last),
        .state_o   (state),
        .phase_o   (phase),
        .fire_o    (fire),
        .ack_o     (ack),
        .latch_o   (latch)
    );

    assign accept  = state == S_IDLE && AS_START;
    assign last    = offset_q == LAST;
    // the abort's own read-array op is best-effort and never times out
    assign waiting = is_op(state) && state != S_ABORT && phase == PH_WAIT;
    assign tmo_hit = waiting && tmo_q == TMO_CYCLES - 32'd1;

    always_comb begin
        offset_d = accept ? 6'd0 : (ack && state == S_PROG && !last) ? offset_q + 6'd1 : offset_q;
        cnt_d    = accept ? 6'd0 : (ack && state == S_PROG) ? offset_q : cnt_q;
        data_d   = latch ? AS_DATA_IN : data_q;
        tmo_d    = (waiting && !AS_DONE) ? tmo_q + 32'd1 : 32'd0;
        status_d = accept ? 3'b001 : status_q | {tmo_hit && !AS_DONE, ack && state == S_RDARR, 1'b0};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            offset_q <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            tmo_q    <= '0;
            status_q <= '0;
            exec_q   <= 1'b0;
        end else begin
            offset_q <= offset_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            tmo_q    <= tmo_d;
            status_q <= status_d;
            exec_q   <= fire;
        end
    end

    always_comb begin
        AS_OP           = state == S_PROG ? OP_PROG :
                          (state == S_UNLOCK || state == S_ERASE) ? OP_CONF : OP_CMD;
        AS_CMD_DATA_OUT = state == S_UNLOCK ? CMD_UNLOCK :
                          state == S_ERASE  ? CMD_ERASE  :
                          (state == S_RDARR || state == S_ABORT) ? CMD_READ_ARRAY :
                          state == S_PROG   ? data_q : 16'h0000;
        AS_ADDR         = state == S_IDLE ? 23'h0 :
                          {BASE_ADDR[22:6], (state == S_LOAD || state == S_PROG) ? offset_q : 6'd0};
    end

    assign AS_RD_ADDR    = offset_q;
    assign AS_EXECUTE    = exec_q;
    assign AUTO_SAVE_ENA = state != S_IDLE;
    assign CLR_AS_DONE   = ack;
    assign AS_CNT        = cnt_q;
    assign AS_STATUS     = status_q;
endmodule

// File: tb/tb_auto_save_const.sv
// tb_auto_save_const: randomized constant saves checked against an op-list scoreboard.
module tb_auto_save_const;
    localparam logic [22:0] BASE = 23'h7FC000;
    localparam int NW  = 64;
    localparam int TMO = 100;

    typedef struct packed {
        logic [1:0]  op;
        logic [22:0] addr;
        logic [15:0] data;
    } op_t;

    logic        CLK = 1'b0, RST_N = 1'b0, AS_START = 1'b0, BUSY = 1'b0, AS_DONE;
    logic [15:0] AS_DATA_IN;
    logic [5:0]  AS_RD_ADDR, AS_CNT;
    logic [22:0] AS_ADDR;
    logic [15:0] AS_CMD_DATA_OUT;
    logic [1:0]  AS_OP;
    logic        AS_EXECUTE, AUTO_SAVE_ENA, CLR_AS_DONE;
    logic [2:0]  AS_STATUS;

    op_t         exp_q[$];
    logic [15:0] mem[NW];
    logic [15:0] rf_q;
    logic        done_lvl, spur = 1'b0;
    int          dly, hang_word = -1;
    int          n_chk = 0, n_fail = 0;

    auto_save_const #(.TMO_CYCLES(32'(TMO))) dut (
        .CLK(CLK), .RST_N(RST_N), .AS_START(AS_START), .BUSY(BUSY), .AS_DONE(AS_DONE),
        .AS_DATA_IN(AS_DATA_IN), .AS_RD_ADDR(AS_RD_ADDR), .AS_ADDR(AS_ADDR),
        .AS_CMD_DATA_OUT(AS_CMD_DATA_OUT), .AS_OP(AS_OP), .AS_EXECUTE(AS_EXECUTE),
        .AUTO_SAVE_ENA(AUTO_SAVE_ENA), .CLR_AS_DONE(CLR_AS_DONE), .AS_CNT(AS_CNT),
        .AS_STATUS(AS_STATUS)
    );

    always #5 CLK = ~CLK;

    assign AS_DONE    = done_lvl | spur;
    assign AS_DATA_IN = rf_q;

    // constant register file: data follows the read index by one clock
    always @(posedge CLK) rf_q <= mem[AS_RD_ADDR];

    // BPI engine: done flag rises 5 clocks after EXECUTE, cleared by CLR_AS_DONE
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            done_lvl <= 1'b0;
            dly      <= -1;
        end else begin
            if (CLR_AS_DONE) done_lvl <= 1'b0;
            if (AS_EXECUTE) dly <= (AS_OP == 2'b01 && int'(AS_ADDR[5:0]) == hang_word) ? -1 : 5;
            else if (dly == 1) begin
                done_lvl <= 1'b1;
                dly      <= -1;
            end else if (dly > 1) dly <= dly - 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // scoreboard monitor: every EXECUTE must match the next expected op
    always @(negedge CLK) begin
        op_t e;
        if (RST_N && AS_EXECUTE) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_exec: got %0h expected none", {AS_OP, AS_ADDR, AS_CMD_DATA_OUT});
            end else begin
                e = exp_q.pop_front();
                check("exec_op", 64'({AS_OP, AS_ADDR, AS_CMD_DATA_OUT}), 64'(e));
            end
        end
    end

    task automatic push_expected();
`ifdef AUTO_SAVE_UNLOCK_EN
        exp_q.push_back(op_t'({2'b11, BASE, 16'h0060}));
`endif
        exp_q.push_back(op_t'({2'b11, BASE, 16'h0020}));
        for (int i = 0; i < NW; i++) begin
            exp_q.push_back(op_t'({2'b01, BASE + 23'(i), mem[i]}));
            if (i == hang_word) break;
        end
        exp_q.push_back(op_t'({2'b00, BASE, 16'h00FF}));
    endtask

    task automatic start_save(input bit lat);
        for (int i = 0; i < NW; i++) mem[i] = 16'($urandom);
        push_expected();
        AS_START = 1'b1;
        @(posedge CLK);
        #1 AS_START = 1'b0;
        if (lat) begin
            @(negedge CLK);
            check("ena_after_start", 64'({AUTO_SAVE_ENA, AS_EXECUTE}), 64'(2'b10));
            @(negedge CLK);
            check("start_latency", 64'(AS_EXECUTE), 64'(1));
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (AUTO_SAVE_ENA && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        if (AUTO_SAVE_ENA) fail_now("wait_idle");
    endtask

    task automatic end_checks(input logic [2:0] st, input logic [5:0] cnt);
        check("status", 64'(AS_STATUS), 64'(st));
        check("as_cnt", 64'(AS_CNT), 64'(cnt));
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_exec(input logic [1:0] op, input int word, input bit clr);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!((clr ? CLR_AS_DONE : AS_EXECUTE) && AS_OP == op && int'(AS_ADDR[5:0]) == word) && n < 5000);
        if (n >= 5000) fail_now("wait_exec");
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({AS_RD_ADDR, AS_ADDR, AS_CMD_DATA_OUT, AS_OP, AS_EXECUTE,
                    AUTO_SAVE_ENA, CLR_AS_DONE, AS_CNT, AS_STATUS});
    endfunction

    initial begin
        int ex, n;
        repeat (3) @(posedge CLK);
        #1 check("reset_outputs", all_outs(), 64'(0));
        @(negedge CLK) RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // full save, nominal latency
        start_save(1);
        wait_idle();
        end_checks(3'b011, 6'd63);

        // START and a stray DONE pulse while the word is loading
        start_save(0);
        wait_exec(2'b01, 5, 1);
        @(posedge CLK);
        #1 spur = 1'b1;
        AS_START = 1'b1;
        @(posedge CLK);
        #1 spur = 1'b0;
        AS_START = 1'b0;
        wait_idle();
        end_checks(3'b011, 6'd63);

        // BUSY held high after START
        BUSY = 1'b1;
        start_save(0);
        ex = 0;
        repeat (19) begin
            @(negedge CLK);
            if (AS_EXECUTE) ex++;
        end
        check("no_exec_while_busy", 64'(ex), 64'(0));
        @(posedge CLK);
        #1 BUSY = 1'b0;
        @(negedge CLK);
        check("exec_same_cycle_busy_fall", 64'(AS_EXECUTE), 64'(0));
        @(negedge CLK);
        check("exec_after_busy_fall", 64'(AS_EXECUTE), 64'(1));
        wait_idle();
        end_checks(3'b011, 6'd63);

        // timeout on word 10
        hang_word = 10;
        start_save(0);
        wait_exec(2'b01, 10, 0);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!AS_EXECUTE && n < 1000);
        check("abort_exec_delay", 64'(n), 64'(TMO + 1));
        wait_idle();
        end_checks(3'b101, 6'd9);
        hang_word = -1;

        // reset in the middle of programming word 30
        start_save(0);
        wait_exec(2'b01, 30, 0);
        #2 RST_N = 1'b0;
        #1 check("async_reset_outputs", all_outs(), 64'(0));
        exp_q.delete();
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST_N = 1'b1;
        @(posedge CLK);
        #1 start_save(1);
        wait_idle();
        end_checks(3'b011, 6'd63);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
